alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_fifo.sv | 81 ++++++++
 rtl/alu_op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU operation sequencer:
//   - default ALU widths (function key, operand, result)
//   - ALU function key encodings
//   - sequencer FSM state encoding
//   - queued instruction layout {key, a}
// No ports (package only).

package alu_seq_pkg;

    localparam int KEY_W  = 3;
    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    typedef enum logic [KEY_W-1:0] {
        ADD_RIPPLE = 3'd0,
        ADD        = 3'd1,
        ORXOR      = 3'd2,
        REDOR      = 3'd3,
        REDAND     = 3'd4,
        SHL        = 3'd5,
        SHR        = 3'd6,
        MUL        = 3'd7
    } alu_key_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0]  key;
        logic [OPND_W-1:0] a;
    } instr_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo
//   Synchronous instruction FIFO for the ALU sequencer.
//   Ports:
//     clock, reset      - rising-edge clock, synchronous active-high reset
//     push, push_data   - write request and data (ignored when full)
//     pop               - remove head entry (ignored when empty)
//     head              - current head entry
//     head_next         - entry that becomes head after a pop this cycle,
//                         including a same-cycle push into a single-entry FIFO
//     full, empty       - occupancy flags
//     single            - exactly one entry stored

module alu_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] head_next,
    output logic             full,
    output logic             empty,
    output logic             single
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign single  = (count == CW'(1));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign head       = mem[rd_ptr];
    // With one entry left, the successor of the head can only be the word
    // being pushed in the same cycle.
    assign head_next  = (count > CW'(1)) ? mem[rd_ptr_inc] : push_data;

    // Storage array kept free of reset so it maps onto plain RAM/registers.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // count tells full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Runs a queued program of {key, A} instructions through an external
//   combinational ALU. B is always the low operand nibble of the internal
//   accumulator; each ALU result is written back into the accumulator.
//   Optional build macro: ALU_OP_SEQUENCER_FLAGS_EN adds flags[1:0] = {zero, carry}.
//   Ports:
//     clock, reset            - rising-edge clock, synchronous active-high reset
//     in_valid/in_ready       - instruction push handshake (in_ready = not full)
//     in_key, in_a            - pushed instruction fields
//     run                     - start program (IDLE only)
//     clear_acc               - zero accumulator (IDLE only)
//     alu_key, alu_a, alu_b   - ALU operand outputs
//     alu_result              - ALU result input, sampled in CAPTURE
//     acc                     - accumulator
//     busy                    - high in ISSUE/CAPTURE
//     done                    - one-cycle pulse when the program completes
//     op_count                - instructions retired since run, saturating
//     flags                   - {zero, carry} of last capture (macro builds only)

module alu_op_sequencer
    import alu_seq_pkg::state_t, alu_seq_pkg::IDLE, alu_seq_pkg::ISSUE,
           alu_seq_pkg::CAPTURE, alu_seq_pkg::DONE;
#(
    parameter int DEPTH  = 8,
    parameter int OPND_W = 4,
    parameter int RES_W  = 8,
    parameter int KEY_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [OPND_W-1:0] in_a,
    input  logic              run,
    input  logic              clear_acc,
    output logic [KEY_W-1:0]  alu_key,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_result,
    output logic [RES_W-1:0]  acc,
    output logic              busy,
    output logic              done,
    output logic [7:0]        op_count
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    ,
    output logic [1:0]        flags
`endif
);

`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    import alu_seq_pkg::ADD_RIPPLE, alu_seq_pkg::ADD;
`endif

    localparam int IW = KEY_W + OPND_W;

    state_t         state;
    logic           push_fire;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_single;
    logic           fifo_pop;
    logic [IW-1:0]  fifo_head;
    logic [IW-1:0]  fifo_head_next;

    assign in_ready  = !fifo_full;
    assign push_fire = in_valid && in_ready;
    assign fifo_pop  = (state == CAPTURE);
    assign alu_b     = acc[OPND_W-1:0];

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_fire),
        .push_data ({in_key, in_a}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .single    (fifo_single)
    );

    // Sequencer FSM. ALU operands are loaded on the edge that enters ISSUE so
    // they are stable through ISSUE and CAPTURE; when looping straight from
    // CAPTURE the FIFO's head_next supplies the post-pop head.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            op_count <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            alu_key  <= '0;
            alu_a    <= '0;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
            flags    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_acc) begin
                        acc <= '0;
                    end
                    if (run) begin
                        op_count <= '0;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
                        flags    <= '0;
`endif
                        if (!fifo_empty) begin
                            state   <= ISSUE;
                            busy    <= 1'b1;
                            alu_key <= fifo_head[IW-1:OPND_W];
                            alu_a   <= fifo_head[OPND_W-1:0];
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    acc <= alu_result;
                    if (op_count != 8'hFF) begin
                        op_count <= op_count + 8'd1;
                    end
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
                    flags[1] <= (alu_result == '0);
                    flags[0] <= ((alu_key == KEY_W'(ADD_RIPPLE)) || (alu_key == KEY_W'(ADD)))
                                ? alu_result[OPND_W] : 1'b0;
`endif
                    // Head is popped this edge; keep going if anything remains,
                    // including an instruction arriving right now.
                    if (!fifo_single || push_fire) begin
                        state   <= ISSUE;
                        alu_key <= fifo_head_next[IW-1:OPND_W];
                        alu_a   <= fifo_head_next[OPND_W-1:0];
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Self-checking bench for alu_op_sequencer. A reference ALU drives
//   alu_result from the DUT's ALU outputs; expected accumulator values are
//   queued when instructions are pushed and compared each time an
//   instruction retires (op_count steps by one).

module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_key;
    logic [3:0] in_a;
    logic       run;
    logic       clear_acc;
    logic [2:0] alu_key;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] acc;
    logic       busy;
    logic       done;
    logic [7:0] op_count;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    logic [1:0] flags;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev_op_count;
    logic [7:0] model_acc;

    alu_op_sequencer #(
        .DEPTH  (8),
        .OPND_W (4),
        .RES_W  (8),
        .KEY_W  (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_key     (in_key),
        .in_a       (in_a),
        .run        (run),
        .clear_acc  (clear_acc),
        .alu_key    (alu_key),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .acc        (acc),
        .busy       (busy),
        .done       (done),
        .op_count   (op_count)
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
        ,
        .flags      (flags)
`endif
    );

    always #5 clock = ~clock;

    // Reference 4-bit, 8-function ALU (B is the accumulator low nibble).
    function automatic logic [7:0] alu_ref(input logic [2:0] k, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [7:0] r;
        case (k)
            3'd0, 3'd1: r = {3'b000, {1'b0, a} + {1'b0, b}};
            3'd2:       r = {a | b, a ^ b};
            3'd3:       r = {7'd0, |{a, b}};
            3'd4:       r = {7'd0, &{a, b}};
            3'd5:       r = {4'd0, b} << a;
            3'd6:       r = {4'd0, b >> a};
            default:    r = {4'd0, a} * {4'd0, b};
        endcase
        return r;
    endfunction

    assign alu_result = alu_ref(alu_key, alu_a, alu_b);

    // Scoreboard: every retire must match the next queued accumulator value.
    always @(negedge clock) begin
        if (!reset && (op_count == prev_op_count + 8'd1)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL retire_unexpected acc=%h op_count=%0d queue empty", acc, op_count);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (acc !== e) begin
                    bad++;
                    $display("[TB] FAIL retire_acc got=%h want=%h op_count=%0d", acc, e, op_count);
                end
            end
        end
        prev_op_count = op_count;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] k, input logic [3:0] a);
        in_valid = 1'b1;
        in_key   = k;
        in_a     = a;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_run;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic pulse_clear;
        clear_acc = 1'b1;
        tick();
        clear_acc = 1'b0;
    endtask

    // Waits (bounded) for done; reports cycle index relative to run edge
    // (0 when the bound expires) and number of busy cycles seen before it.
    task automatic wait_done(input int start, output int dcyc, output int bcyc);
        dcyc = 0;
        bcyc = 0;
        for (int c = start; c <= start + 40; c++) begin
            if (busy) bcyc++;
            if (done) begin
                dcyc = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_key    = '0;
        in_a      = '0;
        run       = 1'b0;
        clear_acc = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        total++; if (acc !== 8'h00)     begin bad++; $display("[TB] FAIL reset_acc got=%h want=00", acc); end
        total++; if (op_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_op_count got=%0d want=0", op_count); end
        total++; if (done !== 1'b0)     begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (alu_key !== 3'd0)  begin bad++; $display("[TB] FAIL reset_alu_key got=%0d want=0", alu_key); end
        total++; if (alu_a !== 4'd0)    begin bad++; $display("[TB] FAIL reset_alu_a got=%0d want=0", alu_a); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_add;
        int d, b;
        applyStimulus(3'd1, 4'd3);
        applyStimulus(3'd1, 4'd5);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h08);
        start_run();
        wait_done(1, d, b);
        total++; if (d != 5) begin bad++; $display("[TB] FAIL add_done_cycle got=%0d want=5", d); end
        total++; if (b != 4) begin bad++; $display("[TB] FAIL add_busy_cycles got=%0d want=4", b); end
        tick();
        total++; if (op_count !== 8'd2) begin bad++; $display("[TB] FAIL add_op_count got=%0d want=2", op_count); end
        total++; if (acc !== 8'h08)     begin bad++; $display("[TB] FAIL add_acc got=%h want=08", acc); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL add_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_mul;
        int d, b;
        applyStimulus(3'd7, 4'd4);
        exp_q.push_back(8'h20);
        start_run();
        wait_done(1, d, b);
        total++; if (d != 3) begin bad++; $display("[TB] FAIL mul_done_cycle got=%0d want=3", d); end
        total++; if (b != 2) begin bad++; $display("[TB] FAIL mul_busy_cycles got=%0d want=2", b); end
        tick();
        total++; if (acc !== 8'h20)    begin bad++; $display("[TB] FAIL mul_acc got=%h want=20", acc); end
        total++; if (alu_key !== 3'd7) begin bad++; $display("[TB] FAIL mul_key_hold got=%0d want=7", alu_key); end
        total++; if (alu_a !== 4'd4)   begin bad++; $display("[TB] FAIL mul_a_hold got=%0d want=4", alu_a); end
    endtask

    task automatic test_shift;
        int d, b;
        pulse_clear();
        total++; if (acc !== 8'h00) begin bad++; $display("[TB] FAIL clear_acc got=%h want=00", acc); end
        applyStimulus(3'd1, 4'd3);
        applyStimulus(3'd5, 4'd2);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h0C);
        start_run();
        wait_done(1, d, b);
        total++; if (d != 5) begin bad++; $display("[TB] FAIL shift_done_cycle got=%0d want=5", d); end
        tick();
        total++; if (acc !== 8'h0C)     begin bad++; $display("[TB] FAIL shift_acc got=%h want=0c", acc); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL shift_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_full;
        instr_t prog[8];
        int d, b;
        prog = '{'{3'd1, 4'd1}, '{3'd2, 4'd5}, '{3'd0, 4'd9}, '{3'd7, 4'd3},
                 '{3'd6, 4'd1}, '{3'd3, 4'd0}, '{3'd5, 4'd2}, '{3'd4, 4'd7}};
        model_acc = 8'h0C;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(prog[i].key, prog[i].a);
            model_acc = alu_ref(prog[i].key, prog[i].a, model_acc[3:0]);
            exp_q.push_back(model_acc);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready got=%b want=0", in_ready); end
        applyStimulus(3'd1, 4'd15);
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_drop_ready got=%b want=0", in_ready); end
        start_run();
        wait_done(1, d, b);
        total++; if (d != 17) begin bad++; $display("[TB] FAIL full_done_cycle got=%0d want=17", d); end
        tick();
        total++; if (op_count !== 8'd8)  begin bad++; $display("[TB] FAIL full_op_count got=%0d want=8", op_count); end
        total++; if (acc !== model_acc)  begin bad++; $display("[TB] FAIL full_acc got=%h want=%h", acc, model_acc); end
        total++; if (exp_q.size() != 0)  begin bad++; $display("[TB] FAIL full_pending got=%0d want=0", exp_q.size()); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL full_drain_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_empty_run;
        int d, b;
        start_run();
        wait_done(1, d, b);
        total++; if (d != 1) begin bad++; $display("[TB] FAIL empty_done_cycle got=%0d want=1", d); end
        total++; if (b != 0) begin bad++; $display("[TB] FAIL empty_busy got=%0d want=0", b); end
        total++; if (acc !== model_acc) begin bad++; $display("[TB] FAIL empty_acc got=%h want=%h", acc, model_acc); end
        total++; if (op_count !== 8'd0) begin bad++; $display("[TB] FAIL empty_op_count got=%0d want=0", op_count); end
        tick();
    endtask

    task automatic test_mid_reset;
        int  d, b;
        logic saw_done;
        pulse_clear();
        for (int i = 0; i < 4; i++) applyStimulus(3'd1, 4'd1);
        exp_q.push_back(8'h01);
        start_run();
        saw_done = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            saw_done |= done;
            tick();
        end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=1", busy); end
        saw_done |= done;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        saw_done |= done;
        total++; if (acc !== 8'h00)     begin bad++; $display("[TB] FAIL midrst_acc got=%h want=00", acc); end
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL midrst_busy_after got=%b want=0", busy); end
        total++; if (saw_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done got=%b want=0", saw_done); end
        total++; if (op_count !== 8'd0) begin bad++; $display("[TB] FAIL midrst_op_count got=%0d want=0", op_count); end
        total++; if (alu_key !== 3'd0)  begin bad++; $display("[TB] FAIL midrst_alu_key got=%0d want=0", alu_key); end
        start_run();
        wait_done(1, d, b);
        total++; if (d != 1) begin bad++; $display("[TB] FAIL midrst_fifo_empty got=%0d want=1", d); end
        tick();
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL midrst_pending got=%0d want=0", exp_q.size()); end
        model_acc = 8'h00;
    endtask

    task automatic test_back_to_back;
        int d, b;
        pulse_clear();
        applyStimulus(3'd1, 4'd1);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        start_run();
        in_valid = 1'b1;
        in_key   = 3'd1;
        in_a     = 4'd1;
        tick();
        in_valid = 1'b0;
        wait_done(2, d, b);
        total++; if (d != 5) begin bad++; $display("[TB] FAIL b2b_done_cycle got=%0d want=5", d); end
        tick();
        total++; if (acc !== 8'h02)     begin bad++; $display("[TB] FAIL b2b_acc got=%h want=02", acc); end
        total++; if (op_count !== 8'd2) begin bad++; $display("[TB] FAIL b2b_op_count got=%0d want=2", op_count); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL b2b_pending got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        $display("[TB] starting alu_op_sequencer bench");
        test_reset();
        test_add();
        test_mul();
        test_shift();
        test_full();
        test_empty_run();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
